// File: rtl/dut_pkg.sv
// Shared encodings for the execution controller: vector modes, FSM states,
// and small decode helpers for the trigger-driven modes.
package dut_pkg;

   typedef enum logic [1:0] {
      MODE_IMM      = 2'b00,
      MODE_DELAY    = 2'b01,
      MODE_MATCH    = 2'b10,
      MODE_MISMATCH = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   function automatic logic is_wait_mode(input mode_e mode);
      return (mode == MODE_MATCH) || (mode == MODE_MISMATCH);
   endfunction

   // Trigger event for the compare modes; never fires in immediate/delay modes.
   function automatic logic trig_hit(input mode_e mode, input logic match);
      logic hit;
      case (mode)
         MODE_MATCH:    hit = match;
         MODE_MISMATCH: hit = ~match;
         default:       hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/dut_trig_match.sv
// Masked response compare: match is high when every masked bit of data
// equals the corresponding bit of value.
module dut_trig_match #(
   parameter int RTF_WIDTH = 24
) (
   input  logic [RTF_WIDTH-1:0] data,
   input  logic [RTF_WIDTH-1:0] mask,
   input  logic [RTF_WIDTH-1:0] value,
   output logic                 match
);

   assign match = (((data ^ value) & mask) == {RTF_WIDTH{1'b0}});

endmodule

// File: rtl/dut_exec_ctrl.sv
// Single-vector execution controller: drives one stimulus vector, waits per its
// mode for a delay or a response trigger, and captures a result record.
module dut_exec_ctrl
   import dut_pkg::*;
#(
   parameter int STF_WIDTH   = 24,
   parameter int RTF_WIDTH   = 24,
   parameter int CYCLE_RANGE = 8
) (
   input  logic                   clock_gated,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic [RTF_WIDTH-1:0]   cfg_trig_mask,
   input  logic [RTF_WIDTH-1:0]   cfg_trig_value,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_mode,
   input  logic [CYCLE_RANGE-1:0] in_cycles,
   input  logic [STF_WIDTH-1:0]   in_data,
   output logic [STF_WIDTH-1:0]   mosi_data,
   input  logic [RTF_WIDTH-1:0]   miso_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [RTF_WIDTH-1:0]   out_result,
   output logic                   out_timeout,
   output logic [CYCLE_RANGE-1:0] out_cycles,
   output logic [1:0]             out_mode,
   output logic                   busy
);

   state_e                 state_q;
   mode_e                  mode_q;
   logic [CYCLE_RANGE-1:0] cycles_q;
   logic [CYCLE_RANGE-1:0] counter_q;
   logic [CYCLE_RANGE-1:0] counter_d;
   logic [STF_WIDTH-1:0]   mosi_q;
   logic                   out_valid_q;
   logic [RTF_WIDTH-1:0]   out_result_q;
   logic                   out_timeout_q;
   logic [CYCLE_RANGE-1:0] out_cycles_q;
   mode_e                  out_mode_q;

   logic match_s;
   logic limit_s;
   logic trig_s;
   logic mode_done_s;
   logic done_s;
   logic timeout_s;
   logic ready_s;
   logic accept_s;

   dut_trig_match #(
      .RTF_WIDTH (RTF_WIDTH)
   ) u_trig_match (
      .data  (miso_data),
      .mask  (cfg_trig_mask),
      .value (cfg_trig_value),
      .match (match_s)
   );

   // Completion decode and handshake qualification for the current cycle
   always_comb begin
      limit_s   = (counter_q == cycles_q);
      trig_s    = trig_hit(mode_q, match_s);
      counter_d = counter_q + CYCLE_RANGE'(1);
      case (mode_q)
         MODE_IMM:      mode_done_s = 1'b1;
         MODE_DELAY:    mode_done_s = limit_s;
         MODE_MATCH:    mode_done_s = trig_s | limit_s;
         MODE_MISMATCH: mode_done_s = trig_s | limit_s;
         default:       mode_done_s = 1'b1;
      endcase
      done_s    = (state_q == ST_WAIT) & mode_done_s;
      // A trigger on the final compare is reported as a trigger, not a timeout.
      timeout_s = is_wait_mode(mode_q) & ~trig_s;
      ready_s   = (state_q == ST_IDLE) & ~flush & (~out_valid_q | out_ready);
      accept_s  = in_valid & ready_s;
   end

   // Control FSM, wait counter, stimulus register and result record
   always_ff @(posedge clock_gated or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         mode_q        <= MODE_IMM;
         cycles_q      <= {CYCLE_RANGE{1'b0}};
         counter_q     <= {CYCLE_RANGE{1'b0}};
         mosi_q        <= {STF_WIDTH{1'b0}};
         out_valid_q   <= 1'b0;
         out_result_q  <= {RTF_WIDTH{1'b0}};
         out_timeout_q <= 1'b0;
         out_cycles_q  <= {CYCLE_RANGE{1'b0}};
         out_mode_q    <= MODE_IMM;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         counter_q   <= {CYCLE_RANGE{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  mosi_q    <= in_data;
                  mode_q    <= mode_e'(in_mode);
                  cycles_q  <= in_cycles;
                  counter_q <= {CYCLE_RANGE{1'b0}};
                  state_q   <= ST_WAIT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (done_s) begin
                  out_result_q  <= miso_data;
                  out_cycles_q  <= counter_q;
                  out_mode_q    <= mode_q;
                  out_timeout_q <= timeout_s;
                  state_q       <= ST_IDLE;
               end else begin
                  counter_q <= counter_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (done_s) begin
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= out_valid_q;
         end
      end
   end

   assign in_ready    = ready_s;
   assign mosi_data   = mosi_q;
   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_timeout = out_timeout_q;
   assign out_cycles  = out_cycles_q;
   assign out_mode    = out_mode_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dut_exec_ctrl.sv
// Bench for dut_exec_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the controller.
module tb_dut_exec_ctrl;

   localparam int STF_W = 24;
   localparam int RTF_W = 24;
   localparam int CR    = 8;

   logic             clock_gated    = 1'b0;
   logic             reset_n        = 1'b0;
   logic             flush          = 1'b0;
   logic [RTF_W-1:0] cfg_trig_mask  = 24'h000000;
   logic [RTF_W-1:0] cfg_trig_value = 24'h000000;
   logic             in_valid       = 1'b0;
   logic             in_ready;
   logic [1:0]       in_mode        = 2'd0;
   logic [CR-1:0]    in_cycles      = 8'd0;
   logic [STF_W-1:0] in_data        = 24'h000000;
   logic [STF_W-1:0] mosi_data;
   logic [RTF_W-1:0] miso_data      = 24'h000000;
   logic             out_valid;
   logic             out_ready      = 1'b0;
   logic [RTF_W-1:0] out_result;
   logic             out_timeout;
   logic [CR-1:0]    out_cycles;
   logic [1:0]       out_mode;
   logic             busy;

   int n_vec = 0;
   int n_err = 0;

   // Model: one vector in flight plus a single pending result record.
   logic             m_busy = 1'b0;
   int               m_cnt  = 0;
   logic [CR-1:0]    m_cyc  = 8'd0;
   logic [1:0]       m_mode = 2'd0;
   logic [STF_W-1:0] m_mosi = 24'h000000;
   logic             m_ov   = 1'b0;
   logic [RTF_W-1:0] m_res  = 24'h000000;
   logic             m_to   = 1'b0;
   logic [CR-1:0]    m_ocyc = 8'd0;
   logic [1:0]       m_omod = 2'd0;

   dut_exec_ctrl #(
      .STF_WIDTH   (STF_W),
      .RTF_WIDTH   (RTF_W),
      .CYCLE_RANGE (CR)
   ) dut (
      .clock_gated    (clock_gated),
      .reset_n        (reset_n),
      .flush          (flush),
      .cfg_trig_mask  (cfg_trig_mask),
      .cfg_trig_value (cfg_trig_value),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_mode        (in_mode),
      .in_cycles      (in_cycles),
      .in_data        (in_data),
      .mosi_data      (mosi_data),
      .miso_data      (miso_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_timeout    (out_timeout),
      .out_cycles     (out_cycles),
      .out_mode       (out_mode),
      .busy           (busy)
   );

   always #5 clock_gated = ~clock_gated;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_busy = 1'b0; m_cnt = 0; m_mosi = 24'h000000; m_ov = 1'b0;
      m_res = 24'h000000; m_to = 1'b0; m_ocyc = 8'd0; m_omod = 2'd0;
   endtask

   function automatic logic model_ready();
      return !m_busy && !flush && (!m_ov || out_ready);
   endfunction

   // Advance the model across one rising edge using the inputs seen before it.
   task automatic model_edge();
      logic rdy, hit, lim, fin;
      rdy = model_ready();
      if (flush) begin
         m_busy = 1'b0;
         m_ov   = 1'b0;
      end else if (m_busy) begin
         hit = (((miso_data ^ cfg_trig_value) & cfg_trig_mask) == 24'h000000);
         if (m_mode == 2'd3) hit = !hit;
         lim = (m_cnt == int'(m_cyc));
         case (m_mode)
            2'd0:    fin = 1'b1;
            2'd1:    fin = lim;
            default: fin = hit || lim;
         endcase
         if (fin) begin
            m_busy = 1'b0;
            m_ov   = 1'b1;
            m_res  = miso_data;
            m_ocyc = 8'(m_cnt);
            m_omod = m_mode;
            m_to   = (m_mode >= 2'd2) && !hit;
         end else begin
            m_cnt++;
            if (out_ready) m_ov = 1'b0;
         end
      end else begin
         if (out_ready) m_ov = 1'b0;
         if (in_valid && rdy) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_cyc  = in_cycles;
            m_mode = in_mode;
            m_mosi = in_data;
         end
      end
   endtask

   task automatic check_outputs();
      chk("in_ready",    32'(in_ready),    32'(model_ready()));
      chk("busy",        32'(busy),        32'(m_busy));
      chk("mosi_data",   32'(mosi_data),   32'(m_mosi));
      chk("out_valid",   32'(out_valid),   32'(m_ov));
      chk("out_result",  32'(out_result),  32'(m_res));
      chk("out_timeout", 32'(out_timeout), 32'(m_to));
      chk("out_cycles",  32'(out_cycles),  32'(m_ocyc));
      chk("out_mode",    32'(out_mode),    32'(m_omod));
   endtask

   // One clock: compare after inputs settle, then step the model at the edge.
   task automatic cyc();
      if (!reset_n) model_clear();
      #1 check_outputs();
      @(posedge clock_gated);
      if (reset_n) model_edge();
      @(negedge clock_gated);
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < budget) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      int n;
      @(posedge clock_gated);
      @(negedge clock_gated);
      cyc();
      cyc();

      // Immediate vector straight out of reset
      reset_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'd0;
      in_data = 24'hA5A5A5; miso_data = 24'h123456;
      #1 chk("ready_after_reset", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      chk("imm_mosi", 32'(mosi_data), 32'hA5A5A5);
      chk("imm_not_yet_valid", 32'(out_valid), 32'd0);
      cyc();
      chk("imm_valid", 32'(out_valid), 32'd1);
      chk("imm_result", 32'(out_result), 32'h123456);
      chk("imm_cycles", 32'(out_cycles), 32'd0);
      chk("imm_timeout", 32'(out_timeout), 32'd0);
      cyc();

      // Delay of 5: result on the 6th edge after accept
      in_valid = 1'b1; in_mode = 2'd1; in_cycles = 8'd5; in_data = 24'h0F0F0F;
      cyc();
      in_valid = 1'b0;
      wait_valid(50, n);
      chk("delay_latency", 32'(n), 32'd6);
      chk("delay_cycles", 32'(out_cycles), 32'd5);
      chk("delay_timeout", 32'(out_timeout), 32'd0);
      cyc();

      // Wait-match: low byte hits 0x42 at counter 7
      cfg_trig_mask = 24'h0000FF; cfg_trig_value = 24'h000042;
      in_valid = 1'b1; in_mode = 2'd2; in_cycles = 8'd20; miso_data = 24'h111100;
      cyc();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         miso_data = {16'($urandom), (n >= 7) ? 8'h42 : 8'h00};
         cyc();
         n++;
      end
      chk("match_latency", 32'(n), 32'd8);
      chk("match_cycles", 32'(out_cycles), 32'd7);
      chk("match_byte", 32'(out_result[7:0]), 32'h42);
      chk("match_timeout", 32'(out_timeout), 32'd0);
      cyc();

      // Wait-mismatch with a constant matching response times out
      cfg_trig_mask = 24'hFFFFFF; cfg_trig_value = 24'h5A5A5A; miso_data = 24'h5A5A5A;
      in_valid = 1'b1; in_mode = 2'd3; in_cycles = 8'd3;
      cyc();
      in_valid = 1'b0;
      wait_valid(50, n);
      chk("mism_to_cycles", 32'(out_cycles), 32'd3);
      chk("mism_to_flag", 32'(out_timeout), 32'd1);
      cyc();

      // Mismatch arriving on the final compare counts as a trigger
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         miso_data = (n >= 3) ? 24'h5A5A5B : 24'h5A5A5A;
         cyc();
         n++;
      end
      chk("mism_trig_cycles", 32'(out_cycles), 32'd3);
      chk("mism_trig_flag", 32'(out_timeout), 32'd0);
      cyc();

      // Zero-cycle wait-match: a single compare that times out
      miso_data = 24'h000000; in_valid = 1'b1; in_mode = 2'd2; in_cycles = 8'd0;
      cyc();
      in_valid = 1'b0;
      wait_valid(50, n);
      chk("zero_latency", 32'(n), 32'd1);
      chk("zero_timeout", 32'(out_timeout), 32'd1);
      cyc();

      // Backpressure holds the result and blocks new vectors
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_data = 24'h777777;
      miso_data = 24'hABCDEF;
      cyc();
      in_data = 24'h888888;
      cyc();
      miso_data = 24'h000001;
      for (int i = 0; i < 10; i++) begin
         chk("bp_ready_low", 32'(in_ready), 32'd0);
         chk("bp_result_hold", 32'(out_result), 32'hABCDEF);
         cyc();
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
      cyc();
      chk("bp_accept_mosi", 32'(mosi_data), 32'h888888);
      in_valid = 1'b0;
      cyc();
      cyc();

      // Flush at counter 4 of a 10-cycle delay
      in_valid = 1'b1; in_mode = 2'd1; in_cycles = 8'd10; in_data = 24'h3C3C3C;
      cyc();
      in_valid = 1'b0;
      repeat (4) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_idle", 32'(busy), 32'd0);
      chk("flush_no_valid", 32'(out_valid), 32'd0);
      chk("flush_mosi_hold", 32'(mosi_data), 32'h3C3C3C);
      repeat (15) cyc();

      // Reset pulse mid-wait discards the vector
      in_valid = 1'b1; in_data = 24'h1E1E1E;
      cyc();
      in_valid = 1'b0;
      repeat (3) cyc();
      reset_n = 1'b0;
      #1;
      chk("rst_mosi", 32'(mosi_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      cyc();
      reset_n = 1'b1;
      repeat (15) cyc();

      // Randomized traffic, including cfg changes during WAIT
      for (int i = 0; i < 4000; i++) begin
         if (i % 50 == 0) begin
            case ($urandom_range(0, 3))
               0:       cfg_trig_mask = 24'h000000;
               1:       cfg_trig_mask = 24'h000003;
               2:       cfg_trig_mask = 24'h00000F;
               default: cfg_trig_mask = 24'hFFFFFF;
            endcase
            cfg_trig_value = 24'($urandom);
         end
         in_valid  = ($urandom_range(0, 2) != 0);
         in_mode   = 2'($urandom_range(0, 3));
         in_cycles = 8'($urandom_range(0, 9));
         in_data   = 24'($urandom);
         miso_data = 24'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         reset_n   = ($urandom_range(0, 500) != 0);
         cyc();
      end
      reset_n = 1'b1;
      flush   = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
